ring_decoder: RTL and testbench

Receive-side companion to the `ringcounter` one-hot phase generator. Samples the N-bit one-hot ring vector and the same `en` that drives the counter, decodes the hot position to a binary index, and tracks rotation to count laps. Checks every sampled vector against the predicted next phase and raises a sticky error on illegal codes, skipped phases, stalls or spurious advances. Sits beside any `ringcounter` instance as a phase-to-index converter and integrity monitor.

---
 rtl/ring_decoder.sv | 159 +++++++++++++++
 tb/tb_ring_decoder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_decoder.sv
// ring_decoder: one-hot ring phase decoder and integrity monitor.
// Decodes the hot bit of a ring counter vector to a binary index and counts
// N-1 -> 0 wraps. It also flags any sample that differs from the phase
// predicted from the previous sample and that sample's enable.
// Optional feature macro: RINGDEC_RESYNC_EN.
//   When defined, FAULT falls back to SYNC after two consistent legal samples.
//   When undefined, FAULT is terminal until reset.
module ring_decoder #(
  parameter int unsigned N = 6,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] q,
  output logic [W-1:0] idx,
  output logic         valid,
  output logic         lap,
  output logic [7:0]   lap_count,
  output logic         err,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t         state_q;
  state_t         state_d;
  logic [N-1:0]   q_prev;
  logic           en_prev;

  logic [W-1:0]   idx_d;
  logic           valid_d;
  logic           lap_d;
  logic [7:0]     lap_count_d;
  logic           err_d;

  logic           legal;
  logic [N-1:0]   expect_q;
  logic           match;
  logic           wrap;
  logic [W-1:0]   pos;

`ifdef RINGDEC_RESYNC_EN
  logic           rs_q;
  logic           rs_d;
`endif

  // A vector is legal when it is non-zero and has exactly one bit set.
  assign legal = (q != '0) && ((q & (q - N'(1))) == '0);

  // Predicted phase: the counter moved one place if and only if it was enabled.
  assign expect_q = en_prev ? {q_prev[N-2:0], q_prev[N-1]} : q_prev;

  // A sample is consistent when it is legal and equals the prediction.
  assign match = legal && (q == expect_q);

  // A wrap is an enabled step from phase N-1 to phase 0.
  assign wrap = q_prev[N-1] && en_prev && q[0];

  // Encode the hot bit by ORing the indices of all set bits. This gives the
  // exact position for a legal vector and needs no priority chain.
  always_comb begin
    pos = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (q[i]) pos = pos | W'(i);
    end
  end

  // Compute the next state and the next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx;
    valid_d     = valid;
    lap_d       = 1'b0;
    lap_count_d = lap_count;
    err_d       = err;
`ifdef RINGDEC_RESYNC_EN
    rs_d        = 1'b0;
`endif
    case (state_q)
      SYNC: begin
        valid_d = 1'b0;
        if (legal) begin
          state_d     = TRACK;
          idx_d       = pos;
          valid_d     = 1'b1;
          lap_count_d = 8'd0;
        end
      end
      TRACK: begin
        if (match) begin
          idx_d = pos;
          if (wrap) begin
            lap_d       = 1'b1;
            lap_count_d = lap_count + 8'd1;
          end
        end else begin
          state_d = FAULT;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end
      end
      FAULT: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
`ifdef RINGDEC_RESYNC_EN
        // rs_q records that the previous sample was a legal vector.
        if (legal) begin
          if (rs_q && match) begin
            state_d = SYNC;
          end else begin
            rs_d = 1'b1;
          end
        end
`endif
      end
      default: begin
        state_d = SYNC;
        valid_d = 1'b0;
      end
    endcase
  end

  // Register the sampled inputs, the FSM state and the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SYNC;
      q_prev    <= '0;
      en_prev   <= 1'b0;
      idx       <= '0;
      valid     <= 1'b0;
      lap       <= 1'b0;
      lap_count <= 8'd0;
      err       <= 1'b0;
`ifdef RINGDEC_RESYNC_EN
      rs_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      q_prev    <= q;
      en_prev   <= en;
      idx       <= idx_d;
      valid     <= valid_d;
      lap       <= lap_d;
      lap_count <= lap_count_d;
      err       <= err_d;
`ifdef RINGDEC_RESYNC_EN
      rs_q      <= rs_d;
`endif
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_ring_decoder.sv
// tb_ring_decoder: directed and randomized checks of ring_decoder against a
// phase-number reference model.
module tb_ring_decoder;

  localparam int N = 6;
  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         en;
  logic [N-1:0] q;
  logic [W-1:0] idx;
  logic         valid;
  logic         lap;
  logic [7:0]   lap_count;
  logic         err;
  logic [1:0]   state;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, kept in phase numbers. The value -1 means an illegal vector.
  int m_mode, m_idx, m_valid, m_lap, m_lc, m_err, m_pp, m_pe, m_rs;
  int ring_ph;
  int held;

  ring_decoder #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset), .en(en), .q(q),
    .idx(idx), .valid(valid), .lap(lap), .lap_count(lap_count),
    .err(err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int phase_of(input logic [N-1:0] v);
    int c = 0;
    int p = -1;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        c++;
        p = i;
      end
    end
    return (c == 1) ? p : -1;
  endfunction

  task automatic model_step(input logic rst, input logic e, input logic [N-1:0] qv);
    int p;
    int ex;
    if (rst) begin
      m_mode = 0; m_idx = 0; m_valid = 0; m_lap = 0; m_lc = 0; m_err = 0;
      m_pp = -1; m_pe = 0; m_rs = 0;
    end else begin
      p  = phase_of(qv);
      ex = (m_pp < 0) ? -2 : (m_pe != 0 ? (m_pp + 1) % N : m_pp);
      m_lap = 0;
      if (m_mode == 0) begin
        m_rs = 0;
        if (p >= 0) begin
          m_mode = 1; m_idx = p; m_valid = 1; m_lc = 0;
        end
      end else if (m_mode == 1) begin
        m_rs = 0;
        if (p >= 0 && p == ex) begin
          m_idx = p;
          if (m_pe != 0 && m_pp == N - 1 && p == 0) begin
            m_lap = 1;
            m_lc  = (m_lc + 1) % 256;
          end
        end else begin
          m_mode = 2; m_err = 1; m_valid = 0;
        end
      end else begin
        m_valid = 0;
`ifdef RINGDEC_RESYNC_EN
        if (p >= 0) begin
          if (m_rs != 0 && p == ex) begin
            m_mode = 0; m_rs = 0;
          end else begin
            m_rs = 1;
          end
        end else begin
          m_rs = 0;
        end
`endif
      end
      m_pp = p;
      m_pe = int'(e);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic check_all();
    check("idx",       32'(idx),       32'(m_idx));
    check("valid",     32'(valid),     32'(m_valid));
    check("lap",       32'(lap),       32'(m_lap));
    check("lap_count", 32'(lap_count), 32'(m_lc));
    check("err",       32'(err),       32'(m_err));
    check("state",     32'(state),     32'(m_mode));
  endtask

  // One clock with explicit inputs; model and outputs compared after the edge.
  task automatic drive_cycle(input logic rst, input logic e, input logic [N-1:0] qv);
    reset = rst;
    en    = e;
    q     = qv;
    @(posedge clk);
    model_step(rst, e, qv);
    #1;
    check_all();
  endtask

  // One clock driven by a well-behaved ring counter that advances when enabled.
  task automatic ring_cycle(input logic rst, input logic e);
    logic [N-1:0] v;
    v = N'(1) << ring_ph;
    drive_cycle(rst, e, v);
    if (rst) ring_ph = 0;
    else if (e) ring_ph = (ring_ph + 1) % N;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; q = '0; ring_ph = 0;
    model_step(1'b1, 1'b0, '0);

    // Reset hold with the ring parked at phase 0.
    for (int i = 0; i < 10; i++) ring_cycle(1'b1, 1'b0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);

    // Normal rotation: one idle cycle, then continuous enable.
    ring_cycle(1'b0, 1'b0);
    check("sync_valid", 32'(valid), 32'd1);
    for (int i = 0; i < 13; i++) ring_cycle(1'b0, 1'b1);
    check("lap_count_12", 32'(lap_count), 32'd2);
    for (int i = 0; i < 87; i++) ring_cycle(1'b0, 1'b1);
    check("rot_err", 32'(err), 32'd0);

    // Enable gaps.
    for (int i = 0; i < 50; i++) ring_cycle(1'b0, 1'($urandom_range(0, 1)));
    check("gap_err", 32'(err), 32'd0);

    // Illegal multi-hot code while tracking.
    held = m_idx;
    drive_cycle(1'b0, 1'b0, 6'b000011);
    check("ill_err",   32'(err),   32'd1);
    check("ill_state", 32'(state), 32'd2);
    check("ill_valid", 32'(valid), 32'd0);
    check("ill_idx",   32'(idx),   32'(held));
    // A clean rotation after the fault: resync if enabled, otherwise stay faulted.
    for (int i = 0; i < 4; i++) ring_cycle(1'b0, 1'b1);
`ifdef RINGDEC_RESYNC_EN
    check("resync_state", 32'(state), 32'd1);
    check("resync_valid", 32'(valid), 32'd1);
`else
    check("terminal_state", 32'(state), 32'd2);
`endif
    check("sticky_err", 32'(err), 32'd1);

    // Skip: 000001 with enable, then 000100.
    drive_cycle(1'b1, 1'b0, 6'b000001);
    drive_cycle(1'b0, 1'b1, 6'b000001);
    drive_cycle(1'b0, 1'b1, 6'b000100);
    check("skip_err", 32'(err), 32'd1);

    // Spurious move: 000001 without enable, then 000010.
    drive_cycle(1'b1, 1'b0, 6'b000001);
    drive_cycle(1'b0, 1'b0, 6'b000001);
    drive_cycle(1'b0, 1'b0, 6'b000010);
    check("spur_err", 32'(err), 32'd1);

    // Stall: enabled but unchanged.
    drive_cycle(1'b1, 1'b0, 6'b000001);
    drive_cycle(1'b0, 1'b1, 6'b000001);
    drive_cycle(1'b0, 1'b1, 6'b000001);
    check("stall_err", 32'(err), 32'd1);

    // Reverse rotation.
    drive_cycle(1'b1, 1'b0, 6'b000010);
    drive_cycle(1'b0, 1'b1, 6'b000010);
    drive_cycle(1'b0, 1'b1, 6'b000001);
    check("rev_err", 32'(err), 32'd1);

    // Mid-lap reset.
    ring_ph = 0;
    ring_cycle(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) ring_cycle(1'b0, 1'b1);
    ring_cycle(1'b1, 1'b1);
    check("mid_rst_idx",   32'(idx),       32'd0);
    check("mid_rst_valid", 32'(valid),     32'd0);
    check("mid_rst_lc",    32'(lap_count), 32'd0);
    check("mid_rst_state", 32'(state),     32'd0);

    // Lap counter wrap past 255.
    for (int i = 0; i < 1560; i++) ring_cycle(1'b0, 1'b1);

    // Randomized mix of clean rotation, corrupted samples and resets.
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2) ring_cycle(1'b1, 1'($urandom_range(0, 1)));
      else if (r < 5) drive_cycle(1'b0, 1'($urandom_range(0, 1)), N'($urandom));
      else ring_cycle(1'b0, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
